ip_send: RTL and testbench
==========================

IP_SEND -- requirements
Module: ip_send

Interface
REQ-001 Parameter TTL, default 8'd128, time-to-live byte written into every header.
REQ-002 Parameter DONT_FRAG, default 1'b0, value of the DF flag bit (header byte 6 bit 6).
REQ-003 tx_clock  in  1  sole clock; all logic on rising edge.
REQ-004 reset_n  in  1  reset, synchronous and active-low.
REQ-005 tx_enable  in  1  MAC grant; high for the whole IP frame, first high cycle starts a packet.
REQ-006 length  in  16  payload byte count (e.g. ICMP length), sampled at start.
REQ-007 protocol  in  8  IP protocol number, sampled at start.
REQ-008 local_ip  in  32  source address, sampled at start.
REQ-009 destination_ip  in  32  destination address, sampled at start.
REQ-010 payload_active  in  1  payload source has a byte on payload_data.
REQ-011 payload_data  in  8  payload byte stream.
REQ-012 payload_enable  out  1  grant to the payload source (drives its tx_enable).
REQ-013 tx_active  out  1  ip_send is producing a valid byte.
REQ-014 tx_data  out  8  IPv4 header then payload, MSB-first per field.

Function
REQ-015 States IDLE, HEADER, PAYLOAD; 5-bit header byte counter byte_no.
REQ-016 IDLE->HEADER when tx_enable high; same edge latches length+20 (mod 2^16), protocol, local_ip, destination_ip, and clears byte_no and the checksum accumulator.
REQ-017 Header byte k is on tx_data in the cycle byte_no==k, k=0..19; byte 0 appears the cycle after tx_enable is first sampled high.
REQ-018 Header bytes: 45, 00, total_len[15:8], total_len[7:0], id[15:8], id[7:0], {0,DONT_FRAG,6'b0}, 00, TTL, protocol, csum[15:8], csum[7:0], src[31:0], dst[31:0].
REQ-019 Identification is a 16-bit counter, incremented on entry to PAYLOAD, wraps FFFF->0000.
REQ-020 Checksum: 20-bit accumulator adds one 16-bit header word (csum word excluded) per cycle at byte_no 0..8; at byte_no 9 registered csum = ~fold(fold(sum)), fold(x)=x[15:0]+x[19:16].
REQ-021 payload_enable SHALL be high from byte_no 19 and throughout PAYLOAD, low otherwise.
REQ-022 HEADER->PAYLOAD after byte 19; in PAYLOAD tx_data=payload_data combinationally.
REQ-023 PAYLOAD->IDLE on the first cycle payload_active is low; that cycle tx_active low.
REQ-024 tx_active = (state==HEADER) | (state==PAYLOAD & payload_active).
REQ-025 tx_enable low during HEADER or PAYLOAD aborts to IDLE next edge; identification not incremented if abort precedes PAYLOAD.
REQ-026 Zero-length payload (payload_active low at first PAYLOAD cycle) returns to IDLE; header still fully sent.
REQ-027 tx_enable still high on return to IDLE does not restart; a new packet needs tx_enable low for at least one cycle.
REQ-028 tx_data is 8'h00 in IDLE.

Reset
REQ-029 reset_n low: state IDLE, byte_no 0, identification 0, accumulator and csum 0; tx_active, payload_enable, tx_data all 0 next cycle.
REQ-030 Reset mid-packet wins over all other events and discards the packet without emitting further bytes.

Structure
REQ-031 Shared package holds IP_HDR_LEN=20, IP_VER_IHL=8'h45, PROTO_ICMP=8'd1, PROTO_UDP=8'd17.
REQ-032 One sub-module, ip_checksum (clear, add-word enable, 16-bit word in, 16-bit complemented result out), reusable by the UDP path.

Verification
REQ-033 length=0x0040, protocol=01, src C0A8010A, dst C0A80101, id 0, TTL 128 -> header 45 00 00 54 00 00 00 00 80 01 B7 4D C0 A8 01 0A C0 A8 01 01.
REQ-034 Same packet with 64-byte incrementing payload -> 84 tx_active cycles, payload_enable rises at byte 19, payload bytes 00..3F follow contiguously, id becomes 0001.
REQ-035 Two back-to-back packets with id preset to FFFF -> ids FFFF then 0000, checksums differ accordingly.
REQ-036 tx_enable dropped at byte_no 7 -> tx_active low next cycle, id unchanged, next packet header correct.
REQ-037 reset_n low during PAYLOAD byte 10 -> all outputs 0 next cycle, id 0, next packet starts from byte 0.
REQ-038 payload_active low at first PAYLOAD cycle -> exactly 20 bytes emitted, state IDLE.

Source files
------------

// File: rtl/ip_send_pkg.sv
// Shared constants and helpers for the IPv4 transmit path.
package ip_send_pkg;

  localparam int unsigned IP_HDR_LEN = 20;
  localparam logic [7:0]  IP_VER_IHL = 8'h45;
  localparam logic [7:0]  PROTO_ICMP = 8'd1;
  localparam logic [7:0]  PROTO_UDP  = 8'd17;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HEADER  = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;

  // One's-complement end-around carry fold of a 20-bit partial sum.
  function automatic logic [19:0] csum_fold(input logic [19:0] x);
    return {4'd0, x[15:0]} + {16'd0, x[19:16]};
  endfunction

endpackage

// File: rtl/ip_checksum.sv
// Internet checksum accumulator: sums 16-bit words, presents the complemented fold.
module ip_checksum
  import ip_send_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        add_en_i,
  input  logic [15:0] word_i,
  output logic [15:0] csum_o
);

  logic [19:0] acc_q, acc_d;
  logic [19:0] fold1, fold2;

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (add_en_i) begin
      acc_d = acc_q + {4'd0, word_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Two folds are enough: at most nine words keep the sum below 2^20.
  assign fold1  = csum_fold(acc_q);
  assign fold2  = csum_fold(fold1);
  assign csum_o = ~fold2[15:0];

endmodule

// File: rtl/ip_send.sv
// IPv4 frame generator: emits a 20-byte header, then forwards the payload stream.
module ip_send
  import ip_send_pkg::*;
#(
  parameter logic [7:0] TTL       = 8'd128,
  parameter logic       DONT_FRAG = 1'b0
) (
  input  logic        tx_clock,
  input  logic        reset_n,
  input  logic        tx_enable,
  input  logic [15:0] length,
  input  logic [7:0]  protocol,
  input  logic [31:0] local_ip,
  input  logic [31:0] destination_ip,
  input  logic        payload_active,
  input  logic [7:0]  payload_data,
  output logic        payload_enable,
  output logic        tx_active,
  output logic [7:0]  tx_data
);

  localparam logic [4:0] LAST_BYTE = 5'(IP_HDR_LEN - 1);
  localparam logic [4:0] LAST_ADD  = 5'd8;
  localparam logic [4:0] CSUM_BYTE = 5'd9;

  logic [1:0]  state_q, state_d;
  logic [4:0]  byte_no_q, byte_no_d;
  logic [15:0] id_q, id_d;
  logic [15:0] total_len_q, total_len_d;
  logic [7:0]  proto_q, proto_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [15:0] csum_q, csum_d;
  logic        en_prev_q;

  logic        start;
  logic        add_en;
  logic [15:0] hdr_word;
  logic [15:0] csum_calc;
  logic [7:0]  hdr_byte;

  // A packet starts only on a rising tx_enable, so a grant held past the end does not restart.
  assign start  = (state_q == ST_IDLE) && tx_enable && !en_prev_q;
  assign add_en = (state_q == ST_HEADER) && (byte_no_q <= LAST_ADD);

  // Header words in checksum order, skipping the checksum word itself.
  always_comb begin
    hdr_word = 16'h0000;
    case (byte_no_q)
      5'd0:    hdr_word = {IP_VER_IHL, 8'h00};
      5'd1:    hdr_word = total_len_q;
      5'd2:    hdr_word = id_q;
      5'd3:    hdr_word = {1'b0, DONT_FRAG, 14'd0};
      5'd4:    hdr_word = {TTL, proto_q};
      5'd5:    hdr_word = src_q[31:16];
      5'd6:    hdr_word = src_q[15:0];
      5'd7:    hdr_word = dst_q[31:16];
      5'd8:    hdr_word = dst_q[15:0];
      default: hdr_word = 16'h0000;
    endcase
  end

  always_comb begin
    hdr_byte = 8'h00;
    case (byte_no_q)
      5'd0:    hdr_byte = IP_VER_IHL;
      5'd1:    hdr_byte = 8'h00;
      5'd2:    hdr_byte = total_len_q[15:8];
      5'd3:    hdr_byte = total_len_q[7:0];
      5'd4:    hdr_byte = id_q[15:8];
      5'd5:    hdr_byte = id_q[7:0];
      5'd6:    hdr_byte = {1'b0, DONT_FRAG, 6'd0};
      5'd7:    hdr_byte = 8'h00;
      5'd8:    hdr_byte = TTL;
      5'd9:    hdr_byte = proto_q;
      5'd10:   hdr_byte = csum_q[15:8];
      5'd11:   hdr_byte = csum_q[7:0];
      5'd12:   hdr_byte = src_q[31:24];
      5'd13:   hdr_byte = src_q[23:16];
      5'd14:   hdr_byte = src_q[15:8];
      5'd15:   hdr_byte = src_q[7:0];
      5'd16:   hdr_byte = dst_q[31:24];
      5'd17:   hdr_byte = dst_q[23:16];
      5'd18:   hdr_byte = dst_q[15:8];
      5'd19:   hdr_byte = dst_q[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  ip_checksum u_csum (
    .clk_i    (tx_clock),
    .rst_ni   (reset_n),
    .clear_i  (start),
    .add_en_i (add_en),
    .word_i   (hdr_word),
    .csum_o   (csum_calc)
  );

  always_comb begin
    state_d     = state_q;
    byte_no_d   = byte_no_q;
    id_d        = id_q;
    total_len_d = total_len_q;
    proto_d     = proto_q;
    src_d       = src_q;
    dst_d       = dst_q;
    csum_d      = csum_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_HEADER;
          byte_no_d   = 5'd0;
          total_len_d = length + 16'(IP_HDR_LEN);
          proto_d     = protocol;
          src_d       = local_ip;
          dst_d       = destination_ip;
        end
      end
      ST_HEADER: begin
        if (byte_no_q == CSUM_BYTE) begin
          csum_d = csum_calc;
        end
        if (!tx_enable) begin
          state_d = ST_IDLE;
        end else if (byte_no_q == LAST_BYTE) begin
          state_d = ST_PAYLOAD;
          id_d    = id_q + 16'd1;
        end else begin
          byte_no_d = byte_no_q + 5'd1;
        end
      end
      ST_PAYLOAD: begin
        if (!tx_enable || !payload_active) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge tx_clock) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      byte_no_q   <= '0;
      id_q        <= '0;
      total_len_q <= '0;
      proto_q     <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      csum_q      <= '0;
      en_prev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_no_q   <= byte_no_d;
      id_q        <= id_d;
      total_len_q <= total_len_d;
      proto_q     <= proto_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      csum_q      <= csum_d;
      en_prev_q   <= tx_enable;
    end
  end

  always_comb begin
    tx_active      = (state_q == ST_HEADER) || ((state_q == ST_PAYLOAD) && payload_active);
    payload_enable = (state_q == ST_PAYLOAD) ||
                     ((state_q == ST_HEADER) && (byte_no_q == LAST_BYTE));
    tx_data        = 8'h00;
    case (state_q)
      ST_HEADER:  tx_data = hdr_byte;
      ST_PAYLOAD: tx_data = payload_data;
      default:    tx_data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_ip_send.sv
// Bench for ip_send: directed and random packets against a byte-level header model.
module tb_ip_send;
  import ip_send_pkg::*;

  logic        tx_clock = 1'b0;
  logic        reset_n;
  logic        tx_enable;
  logic [15:0] length;
  logic [7:0]  protocol;
  logic [31:0] local_ip;
  logic [31:0] destination_ip;
  logic        payload_active;
  logic [7:0]  payload_data;
  logic        payload_enable;
  logic        tx_active;
  logic [7:0]  tx_data;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] model_id;
  logic [7:0]  exp_hdr [20];
  logic [7:0]  pay [64];
  logic [7:0]  golden [20] = '{8'h45, 8'h00, 8'h00, 8'h54, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80,
                               8'h01, 8'hB7, 8'h4D, 8'hC0, 8'hA8, 8'h01, 8'h0A, 8'hC0, 8'hA8,
                               8'h01, 8'h01};

  ip_send dut (
    .tx_clock       (tx_clock),
    .reset_n        (reset_n),
    .tx_enable      (tx_enable),
    .length         (length),
    .protocol       (protocol),
    .local_ip       (local_ip),
    .destination_ip (destination_ip),
    .payload_active (payload_active),
    .payload_data   (payload_data),
    .payload_enable (payload_enable),
    .tx_active      (tx_active),
    .tx_data        (tx_data)
  );

  always #5 tx_clock = ~tx_clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge tx_clock);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    @(negedge tx_clock);
    chk({tag, ".act"}, 32'(tx_active), 32'd0);
    chk({tag, ".pen"}, 32'(payload_enable), 32'd0);
    chk({tag, ".data"}, 32'(tx_data), 32'd0);
  endtask

  // Header bytes straight from the field layout; checksum over all ten words with zero csum.
  task automatic build_hdr(input logic [15:0] len, input logic [7:0] proto,
                           input logic [31:0] src, input logic [31:0] dst);
    logic [15:0] tl;
    logic [15:0] cs;
    int unsigned s;
    tl = len + 16'd20;
    exp_hdr = '{8'h45, 8'h00, tl[15:8], tl[7:0], model_id[15:8], model_id[7:0], 8'h00, 8'h00,
                8'd128, proto, 8'h00, 8'h00, src[31:24], src[23:16], src[15:8], src[7:0],
                dst[31:24], dst[23:16], dst[15:8], dst[7:0]};
    s = 0;
    for (int i = 0; i < 10; i++) s += {16'd0, exp_hdr[2*i], exp_hdr[2*i+1]};
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    cs = ~s[15:0];
    exp_hdr[10] = cs[15:8];
    exp_hdr[11] = cs[7:0];
  endtask

  // Entered and left just after a rising edge, with tx_enable low and the DUT idle.
  task automatic run_packet(input logic [15:0] len, input logic [7:0] proto,
                            input logic [31:0] src, input logic [31:0] dst, input int plen,
                            input int abort_at, input int reset_at, input bit use_golden);
    int act_cnt;
    act_cnt = 0;
    build_hdr(len, proto, src, dst);
    tx_enable      = 1'b1;
    length         = len;
    protocol       = proto;
    local_ip       = src;
    destination_ip = dst;
    payload_active = 1'b0;
    @(negedge tx_clock);
    chk("pre_start.act", 32'(tx_active), 32'd0);
    tick();
    // Fields must have been captured at the start edge.
    length         = 16'($urandom);
    protocol       = 8'($urandom);
    local_ip       = $urandom;
    destination_ip = $urandom;
    for (int k = 0; k < 20; k++) begin
      if (k == abort_at) tx_enable = 1'b0;
      @(negedge tx_clock);
      chk($sformatf("hdr%0d.act", k), 32'(tx_active), 32'd1);
      chk($sformatf("hdr%0d.data", k), 32'(tx_data), 32'(exp_hdr[k]));
      chk($sformatf("hdr%0d.pen", k), 32'(payload_enable), 32'(k == 19));
      if (use_golden) chk($sformatf("gold%0d", k), 32'(tx_data), 32'(golden[k]));
      tick();
      if (k == abort_at) begin
        chk_idle("abort");
        tick();
        return;
      end
    end
    model_id = model_id + 16'd1;
    act_cnt  = 20;
    for (int j = 0; j < plen; j++) begin
      payload_active = 1'b1;
      payload_data   = pay[j];
      if (j == reset_at) reset_n = 1'b0;
      @(negedge tx_clock);
      chk($sformatf("pay%0d.act", j), 32'(tx_active), 32'd1);
      chk($sformatf("pay%0d.data", j), 32'(tx_data), 32'(pay[j]));
      chk($sformatf("pay%0d.pen", j), 32'(payload_enable), 32'd1);
      act_cnt++;
      tick();
      if (j == reset_at) begin
        model_id       = 16'd0;
        reset_n        = 1'b1;
        tx_enable      = 1'b0;
        payload_active = 1'b0;
        chk_idle("reset");
        tick();
        return;
      end
    end
    payload_active = 1'b0;
    payload_data   = 8'($urandom);
    @(negedge tx_clock);
    chk("end.act", 32'(tx_active), 32'd0);
    chk("end.pen", 32'(payload_enable), 32'd1);
    tick();
    chk_idle("post1");
    tick();
    chk_idle("norestart");
    chk("act_cnt", 32'(act_cnt), 32'(20 + plen));
    tick();
    tx_enable = 1'b0;
    tick();
  endtask

  initial begin
    int pl;
    reset_n        = 1'b0;
    tx_enable      = 1'b0;
    length         = '0;
    protocol       = '0;
    local_ip       = '0;
    destination_ip = '0;
    payload_active = 1'b0;
    payload_data   = '0;
    model_id       = 16'd0;
    tick();
    tick();
    chk_idle("reset_state");
    tick();
    reset_n = 1'b1;
    tick();

    // Reference ICMP packet with 64 incrementing payload bytes.
    for (int i = 0; i < 64; i++) pay[i] = 8'(i);
    run_packet(16'h0040, PROTO_ICMP, 32'hC0A8010A, 32'hC0A80101, 64, -1, -1, 1'b1);

    // Random packets, including possibly empty payloads.
    for (int n = 0; n < 4; n++) begin
      pl = int'($urandom_range(0, 12));
      for (int i = 0; i < pl; i++) pay[i] = 8'($urandom);
      run_packet(16'(pl), 8'($urandom), $urandom, $urandom, pl, -1, -1, 1'b0);
    end

    // Identification wrap across two back-to-back packets.
    force dut.id_q = 16'hFFFF;
    tick();
    release dut.id_q;
    model_id = 16'hFFFF;
    pay[0] = 8'hA5;
    pay[1] = 8'h5A;
    run_packet(16'd2, PROTO_UDP, 32'h0A000001, 32'h0A000002, 2, -1, -1, 1'b0);
    run_packet(16'd2, PROTO_UDP, 32'h0A000001, 32'h0A000002, 2, -1, -1, 1'b0);

    // Abort during the header leaves the identification unchanged.
    run_packet(16'd4, PROTO_ICMP, $urandom, $urandom, 4, 7, -1, 1'b0);
    run_packet(16'd1, PROTO_ICMP, $urandom, $urandom, 1, -1, -1, 1'b0);

    // Reset in the middle of the payload, then a fresh packet.
    for (int i = 0; i < 16; i++) pay[i] = 8'($urandom);
    run_packet(16'd16, PROTO_UDP, $urandom, $urandom, 16, -1, 10, 1'b0);
    run_packet(16'd3, PROTO_ICMP, $urandom, $urandom, 3, -1, -1, 1'b0);

    // Header-only packet.
    run_packet(16'd0, PROTO_ICMP, 32'hC0A8010A, 32'hC0A80101, 0, -1, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
